// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one multi-cycle memory port between instruction fetch and the data stage.
// Data side wins ties; a starvation guard forces a fetch grant after STARVE_MAX consecutive data grants.
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [15:0]       i_addr,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [15:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [15:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_TOP  = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TIMEOUT_TOP = TW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                own_d_q, own_d_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_wr_q, mem_wr_d;
  logic [15:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                i_done_q, i_done_d;
  logic                d_done_q, d_done_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                err_q, err_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;

  logic                grant;
  logic [15:0]         grant_addr;
  logic                resp_go;
  logic [DATA_W-1:0]   resp_data;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == STARVE_TOP) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    own_d_d     = own_d_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
    starve_d    = starve_q;
    tcnt_d      = tcnt_q;
    grant       = 1'b0;
    grant_addr  = 16'h0000;
    resp_go     = 1'b0;
    resp_data   = '0;

    case (state_q)
      S_IDLE: begin
        if (d_req && !(i_req && starve_q == STARVE_TOP)) begin
          grant       = 1'b1;
          own_d_d     = 1'b1;
          mem_wr_d    = d_wr;
          grant_addr  = d_addr;
          mem_wdata_d = d_wdata;
          starve_d    = i_req ? sat_inc(starve_q) : '0;
        end else if (i_req) begin
          grant       = 1'b1;
          own_d_d     = 1'b0;
          mem_wr_d    = 1'b0;
          grant_addr  = i_addr;
          mem_wdata_d = '0;
          starve_d    = '0;
        end else begin
          starve_d    = '0;
        end
        // Unaligned accesses never reach memory; they complete immediately with an error.
        if (grant) begin
          mem_addr_d = grant_addr;
          if (grant_addr[0]) begin
            err_d   = 1'b1;
            resp_go = 1'b1;
            state_d = S_RESP;
          end else begin
            mem_en_d = 1'b1;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_done) begin
          resp_go   = 1'b1;
          resp_data = mem_wr_q ? '0 : mem_rdata;
          state_d   = S_RESP;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_d == TIMEOUT_TOP) begin
            err_d   = 1'b1;
            resp_go = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (resp_go) begin
      if (own_d_d) begin
        d_done_d  = 1'b1;
        d_rdata_d = resp_data;
      end else begin
        i_done_d  = 1'b1;
        i_rdata_d = resp_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      own_d_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
      starve_q    <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      own_d_q     <= own_d_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
      starve_q    <= starve_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign i_done    = i_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign i_stall   = i_req & ~i_done_q;
  assign d_stall   = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus starvation, timeout and reset-abort sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = 16'h0;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = 16'h0;
  logic [15:0] d_wdata = 16'h0;
  logic        i_done, i_stall, d_done, d_stall, mem_en, mem_wr, err;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        mem_done = 1'b0;
  logic [15:0] mem_rdata = 16'h0;

  bit mem_auto = 1'b0;
  bit mem_force = 1'b0;
  bit prev_en = 1'b0;

  int passed = 0;
  int total = 0;

  logic        cap_wr;
  logic [15:0] cap_addr, cap_wdata, cap_rdata;
  logic        cap_err;
  int          bad;

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_done(i_done), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  // Memory model: answers one cycle after each issue strobe when enabled.
  always @(posedge clk) begin
    #2;
    mem_done = (mem_auto && prev_en) || mem_force;
    prev_en  = mem_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mrd;
    int          exp_en;
    int          exp_done;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; mem_force = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic xact(input logic is_d, input logic wr, input logic [15:0] addr,
                      input logic [15:0] wdata, output int en_k, output int done_k);
    logic own_done, oth_done, own_stall;
    en_k = -1; done_k = -1; bad = 0;
    if (is_d) begin d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata; end
    else begin i_req = 1'b1; i_addr = addr; end
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (mem_en) begin
        en_k = (en_k < 0) ? k : 99;
        cap_wr = mem_wr; cap_addr = mem_addr; cap_wdata = mem_wdata;
      end
      own_done  = is_d ? d_done : i_done;
      oth_done  = is_d ? i_done : d_done;
      own_stall = is_d ? d_stall : i_stall;
      if (oth_done) bad++;
      if (own_done) begin
        done_k = k;
        cap_rdata = is_d ? d_rdata : i_rdata;
        cap_err = err;
        if (own_stall !== 1'b0) bad++;
        break;
      end else if (own_stall !== 1'b1) bad++;
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    int en_k, done_k, g, sbad;
    logic [6:0] order;
    logic [6:0] exp_order;

    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1, 3, 16'hBEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'h5A5A, 1, 3, 16'h5A5A, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 16'h0022, 16'h1234, 16'hFFFF, 1, 3, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h8001, 1, 3, 16'h8001, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 16'h0003, 16'h9999, 16'hAAAA, -1, 1, 16'h0000, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 16'h0011, 16'h0000, 16'hAAAA, -1, 1, 16'h0000, 1'b1};

    // Reset with both requests asserted: everything must stay cleared.
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0010; d_addr = 16'h0100;
    tick();
    tick();
    chk("rst_i_done", i_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_err", err, 0);
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    tick();
    chk("post_rst_idle_mem_en", mem_en, 0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      mem_auto = 1'b1;
      mem_rdata = vecs[v].mrd;
      xact(vecs[v].is_d, vecs[v].wr, vecs[v].addr, vecs[v].wdata, en_k, done_k);
      chk($sformatf("v%0d_en_cycle", v), en_k, vecs[v].exp_en);
      chk($sformatf("v%0d_done_cycle", v), done_k, vecs[v].exp_done);
      if (vecs[v].exp_en > 0) begin
        chk($sformatf("v%0d_mem_addr", v), cap_addr, vecs[v].addr);
        chk($sformatf("v%0d_mem_wr", v), cap_wr, vecs[v].wr);
        if (vecs[v].wr) chk($sformatf("v%0d_mem_wdata", v), cap_wdata, vecs[v].wdata);
      end
      chk($sformatf("v%0d_rdata", v), cap_rdata, vecs[v].exp_rdata);
      chk($sformatf("v%0d_err", v), cap_err, vecs[v].exp_err);
      chk($sformatf("v%0d_stall_done", v), bad, 0);
      tick();
      tick();
      chk($sformatf("v%0d_err_after", v), err, vecs[v].exp_err);
    end

    // Both sides requesting continuously: expect D,D,D,D,I,D,D.
    do_reset();
    mem_auto = 1'b1; mem_rdata = 16'h7777;
    i_req = 1'b1; i_addr = 16'h0040;
    d_req = 1'b1; d_addr = 16'h0100; d_wr = 1'b0;
    g = 0; sbad = 0; order = '0;
    for (int k = 0; k < 80 && g < 7; k++) begin
      tick();
      if (mem_en) begin
        order[g] = (mem_addr == 16'h0100);
        g++;
      end
      if (i_stall !== ~i_done) sbad++;
    end
    exp_order = 7'b1101111;
    chk("starve_grant_count", g, 7);
    for (int j = 0; j < 7; j++) chk($sformatf("starve_grant%0d_is_d", j), order[j], exp_order[j]);
    chk("starve_i_stall", sbad, 0);
    i_req = 1'b0; d_req = 1'b0;
    tick();
    tick();

    // Timeout after a successful read so stale read data would be visible.
    do_reset();
    mem_auto = 1'b1; mem_rdata = 16'h1357;
    xact(1'b1, 1'b0, 16'h0200, 16'h0000, en_k, done_k);
    chk("to_pre_rdata", cap_rdata, 16'h1357);
    tick();
    mem_auto = 1'b0;
    xact(1'b1, 1'b0, 16'h0204, 16'h0000, en_k, done_k);
    chk("to_en_cycle", en_k, 1);
    chk("to_done_cycle", done_k, 18);
    chk("to_rdata", cap_rdata, 0);
    chk("to_err", cap_err, 1);
    tick();
    tick();
    tick();
    chk("to_err_sticky", err, 1);

    // Reset while waiting on memory, then a stray completion in IDLE.
    do_reset();
    mem_auto = 1'b0;
    i_req = 1'b1; i_addr = 16'h0030;
    tick();
    chk("rw_issue_en", mem_en, 1);
    tick();
    chk("rw_wait_en", mem_en, 0);
    rst = 1'b1; i_req = 1'b0;
    tick();
    chk("rw_rst_addr", mem_addr, 0);
    chk("rw_rst_err", err, 0);
    rst = 1'b0; mem_force = 1'b1;
    tick();
    mem_force = 1'b0;
    chk("rw_stray_i_done", i_done, 0);
    chk("rw_stray_mem_en", mem_en, 0);
    tick();
    tick();
    chk("rw_late_i_done", i_done, 0);
    chk("rw_late_err", err, 0);
    chk("rw_late_rdata", i_rdata, 0);
    mem_auto = 1'b1; mem_rdata = 16'h4242;
    xact(1'b0, 1'b0, 16'h0032, 16'h0000, en_k, done_k);
    chk("rw_next_done_cycle", done_k, 3);
    chk("rw_next_rdata", cap_rdata, 16'h4242);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
